direction_scheduler: RTL and testbench
======================================

Name: direction_scheduler

Overview:
Sits between the PS/2 keyboard decoder and the snake movement logic. It sequences direction commands from two requesters onto the game's move tick: the keyboard one-hot direction bus and a voice-detector direction strobe. Requests are synchronized, arbitrated and legality-filtered (no 180° reversal, no repeat), buffered in a small turn queue, and applied one per move tick.
- Outputs: the current heading and a one-cycle step pulse for the snake datapath.

Parameters:
- TICK_CYCLES, 25_000_000: system clocks per move tick; must be ≥2.
- DEPTH, 2: turn-queue entries, 1..4.
- RESET_DIR, 4'b1000: heading after reset; must be one-hot.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = game running (tick counter advances); 0 = paused.
- key_dir  input  8  keyboard direction; asynchronous to clock; level-held. Encoding: UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000, 0 = none.
- voice_dir  input  4  voice-detector direction; same one-hot encoding; clock domain.
- voice_valid  input  1  one-cycle strobe qualifying voice_dir.
- cur_dir  output  4  current heading, one-hot.
- step  output  1  one-cycle pulse per move tick; cur_dir is already updated when step is high.
- queue_count  output  3  entries held in the turn queue.
- rejected  output  1  one-cycle pulse: request was illegal (repeat or reversal).
- dropped  output  1  one-cycle pulse: request was lost (queue full, or voice lost arbitration).

Behaviour:
- Reset values: cur_dir=RESET_DIR, step=0, queue_count=0, rejected=0, dropped=0, tick counter=0, both sync stages=0, previous-key register=0.
- Reset mid-operation discards queued turns and any partial tick count.
- Keyboard path:
  - key_dir passes through a 2-flop synchronizer, then a previous-value register.
  - A key request fires when the synced value differs from the previous value, bits[7:4]=0, and bits[3:0] are exactly one-hot.
  - Zero or multi-hot values never fire but still update the previous value.
  - Latency: the queue changes on the 3rd rising edge after key_dir changes.
  - The same key held or re-pressed without an intervening change does not refire.
- Voice path: a request fires when voice_valid=1 and voice_dir is one-hot. Non-one-hot values are silently ignored (no pulse).
- Arbitration: at most one candidate per cycle. If both fire, the keyboard wins and voice is discarded with dropped=1.
- Legality check:
  - The candidate is compared to the reference direction: the newest queued entry, or cur_dir if the queue is empty.
  - If equal, or opposite (UP<->DOWN, LEFT<->RIGHT): not enqueued, rejected=1 next cycle.
- Enqueue: a legal candidate with queue_count<DEPTH is written at the tail. If queue_count==DEPTH it is discarded with dropped=1.
  - The fullness check uses the pre-pop count, so a push is dropped even if a pop happens in the same cycle.
- Tick counter:
  - While enable=1 it counts 0..TICK_CYCLES-1 and wraps.
  - On the edge where count==TICK_CYCLES-1 and enable=1: counter<=0, step<=1, and if queue non-empty, cur_dir<=head and the head is popped.
  - With an empty queue, cur_dir holds and step still pulses.
  - step is 0 in every other cycle.
- Pause: with enable=0 the counter holds, step=0, and requests are still accepted and queued.
- Simultaneous push and pop:
  - Both are allowed; queue_count is unchanged.
  - The legality reference is evaluated on pre-edge state. If one entry is popping, that entry remains the reference, which is consistent because it becomes cur_dir.
- rejected and dropped are registered and never both high for the same request.
- cur_dir is always one-hot. Queue storage is a circular buffer with head/tail pointers wrapping at DEPTH.

Test Plan:
- Reset, then TICK_CYCLES=8, enable=1, no input -> cur_dir=1000 throughout, step pulses every 8 clocks, queue_count=0.
- key_dir 0->0001 -> queue_count=1 three clocks later; next tick gives cur_dir=0001 with step=1 in the same cycle, queue_count=0.
- With cur_dir=1000: key_dir=0100 (reversal) -> rejected pulse, queue_count stays 0. Then voice_dir=1000 with voice_valid (repeat) -> rejected pulse.
- DEPTH=2, enable=0, cur_dir=1000:
  - Queue UP via keyboard, LEFT via voice, DOWN via keyboard: queue_count=2 and DOWN is dropped (queue full, pre-pop count).
  - Then enable=1: ticks yield cur_dir 0001 then 0100, then hold.
- The synced keyboard request and voice_valid fire in the same cycle -> the keyboard entry is queued, dropped=1 for voice, queue_count increments by 1.
- Assert reset while queue_count=2 mid-tick -> next cycle cur_dir=1000, queue_count=0, step=0; the first step comes TICK_CYCLES clocks after reset release.

Source files
------------

// File: rtl/direction_scheduler.sv
// rtl/direction_scheduler.sv - sequences keyboard/voice turn requests onto the snake move tick
module direction_scheduler #(
    parameter int         TICK_CYCLES = 25_000_000,
    parameter int         DEPTH       = 2,
    parameter logic [3:0] RESET_DIR   = 4'b1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] key_dir,
    input  logic [3:0] voice_dir,
    input  logic       voice_valid,
    output logic [3:0] cur_dir,
    output logic       step,
    output logic [2:0] queue_count,
    output logic       rejected,
    output logic       dropped
);

    localparam int             CW        = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [1:0]     PTR_LAST  = 2'(DEPTH - 1);
    localparam logic [2:0]     DEPTH_C   = 3'(DEPTH);

    logic [7:0]    r_key_s1;
    logic [7:0]    r_key_s2;
    logic [7:0]    r_key_prev;
    logic [CW-1:0] r_tick;
    logic [3:0]    r_q [4];
    logic [1:0]    r_head;
    logic [1:0]    r_tail;
    logic [2:0]    r_count;
    logic [3:0]    r_cur;
    logic          r_step;
    logic          r_rej;
    logic          r_drop;

    logic          w_key_fire;
    logic          w_voice_fire;
    logic          w_cand_valid;
    logic [3:0]    w_cand;
    logic [1:0]    w_newest_idx;
    logic [3:0]    w_ref;
    logic          w_illegal;
    logic          w_full;
    logic          w_push;
    logic          w_tick;
    logic          w_pop;

    function automatic logic f_onehot(input logic [3:0] d);
        return (d != 4'b0) && ((d & (d - 4'd1)) == 4'b0);
    endfunction

    // Bit order is {RIGHT, LEFT, DOWN, UP}; the opposite swaps within each axis pair.
    function automatic logic [3:0] f_opposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    function automatic logic [1:0] f_ptr_next(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_key_fire   = (r_key_s2 != r_key_prev) && (r_key_s2[7:4] == 4'b0)
                          && f_onehot(r_key_s2[3:0]);
    assign w_voice_fire = voice_valid && f_onehot(voice_dir);
    assign w_cand_valid = w_key_fire || w_voice_fire;
    assign w_cand       = w_key_fire ? r_key_s2[3:0] : voice_dir;

    // Newest queued turn is the reference; a popping entry still counts since it becomes cur_dir.
    assign w_newest_idx = (r_tail == 2'd0) ? PTR_LAST : r_tail - 2'd1;
    assign w_ref        = (r_count != 3'd0) ? r_q[w_newest_idx] : r_cur;
    assign w_illegal    = (w_cand == w_ref) || (w_cand == f_opposite(w_ref));
    assign w_full       = (r_count == DEPTH_C);
    assign w_push       = w_cand_valid && !w_illegal && !w_full;

    assign w_tick       = enable && (r_tick == TICK_LAST);
    assign w_pop        = w_tick && (r_count != 3'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_key_s1   <= 8'b0;
            r_key_s2   <= 8'b0;
            r_key_prev <= 8'b0;
            r_tick     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= 4'b0;
            end
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_count    <= 3'd0;
            r_cur      <= RESET_DIR;
            r_step     <= 1'b0;
            r_rej      <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_key_s1   <= key_dir;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;

            r_step <= 1'b0;
            if (enable) begin
                if (r_tick == TICK_LAST) begin
                    r_tick <= '0;
                    r_step <= 1'b1;
                end else begin
                    r_tick <= r_tick + CW'(1);
                end
            end

            if (w_pop) begin
                r_cur  <= r_q[r_head];
                r_head <= f_ptr_next(r_head);
            end

            if (w_push) begin
                r_q[r_tail] <= w_cand;
                r_tail      <= f_ptr_next(r_tail);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase

            r_rej  <= w_cand_valid && w_illegal;
            r_drop <= (w_key_fire && w_voice_fire)
                      || (w_cand_valid && !w_illegal && w_full);
        end
    end

    assign cur_dir     = r_cur;
    assign step        = r_step;
    assign queue_count = r_count;
    assign rejected    = r_rej;
    assign dropped     = r_drop;

endmodule

// File: tb/tb_direction_scheduler.sv
// tb/tb_direction_scheduler.sv - scoreboard bench for direction_scheduler
module tb_direction_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] key_dir = 8'h00;
    logic [3:0] voice_dir = 4'h0;
    logic       voice_valid = 1'b0;
    logic [3:0] cur_dir;
    logic       step;
    logic [2:0] queue_count;
    logic       rejected;
    logic       dropped;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb [$];
    logic [9:0] mon_exp;
    logic [9:0] mon_got;

    always #5 clock = ~clock;

    direction_scheduler #(
        .TICK_CYCLES(8),
        .DEPTH      (2),
        .RESET_DIR  (4'b1000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .key_dir    (key_dir),
        .voice_dir  (voice_dir),
        .voice_valid(voice_valid),
        .cur_dir    (cur_dir),
        .step       (step),
        .queue_count(queue_count),
        .rejected   (rejected),
        .dropped    (dropped)
    );

    // Event record: {step, rejected, dropped, cur_dir, queue_count}
    function automatic logic [9:0] ev(input logic s, input logic r, input logic d,
                                      input logic [3:0] c, input logic [2:0] q);
        return {s, r, d, c, q};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (step === 1'b1 || rejected === 1'b1 || dropped === 1'b1) begin
            mon_got = {step, rejected, dropped, cur_dir, queue_count};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %b expected none", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL event: got %b expected %b", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cyc(2);
        check("reset_cur", cur_dir, 4'b1000);
        check("reset_step", step, 1'b0);
        check("reset_qc", queue_count, 3'd0);
        check("reset_rej", rejected, 1'b0);
        check("reset_drop", dropped, 1'b0);

        // Free-running ticks with no input
        reset = 1'b0;
        enable = 1'b1;
        sb.push_back(ev(1, 0, 0, 4'b1000, 3'd0));
        sb.push_back(ev(1, 0, 0, 4'b1000, 3'd0));
        cyc(16);
        check("idle_step", step, 1'b1);
        check("idle_cur", cur_dir, 4'b1000);

        // Keyboard UP: visible on the third edge, applied on the next tick
        enable = 1'b0;
        key_dir = 8'h01;
        cyc(2);
        check("key_lat_before", queue_count, 3'd0);
        cyc(1);
        check("key_lat_at", queue_count, 3'd1);
        sb.push_back(ev(1, 0, 0, 4'b0001, 3'd0));
        enable = 1'b1;
        cyc(8);
        check("key_applied_cur", cur_dir, 4'b0001);
        check("key_applied_step", step, 1'b1);
        enable = 1'b0;

        // Reversal via keyboard, repeat via voice
        sb.push_back(ev(0, 1, 0, 4'b0001, 3'd0));
        key_dir = 8'h02;
        cyc(3);
        check("reversal_rej", rejected, 1'b1);
        check("reversal_qc", queue_count, 3'd0);
        sb.push_back(ev(0, 1, 0, 4'b0001, 3'd0));
        voice_dir = 4'b0001;
        voice_valid = 1'b1;
        cyc(1);
        voice_valid = 1'b0;
        check("repeat_rej", rejected, 1'b1);

        // Fill queue while paused, third request dropped
        key_dir = 8'h04;
        cyc(3);
        check("fill_qc1", queue_count, 3'd1);
        voice_dir = 4'b0010;
        voice_valid = 1'b1;
        cyc(1);
        voice_valid = 1'b0;
        check("fill_qc2", queue_count, 3'd2);
        sb.push_back(ev(0, 0, 1, 4'b0001, 3'd2));
        key_dir = 8'h08;
        cyc(3);
        check("full_drop", dropped, 1'b1);
        check("full_qc", queue_count, 3'd2);
        sb.push_back(ev(1, 0, 0, 4'b0100, 3'd1));
        sb.push_back(ev(1, 0, 0, 4'b0010, 3'd0));
        sb.push_back(ev(1, 0, 0, 4'b0010, 3'd0));
        enable = 1'b1;
        cyc(8);
        check("drain_cur1", cur_dir, 4'b0100);
        cyc(8);
        check("drain_cur2", cur_dir, 4'b0010);
        cyc(8);
        check("drain_hold", cur_dir, 4'b0010);
        enable = 1'b0;

        // Keyboard and voice in the same cycle
        sb.push_back(ev(0, 0, 1, 4'b0010, 3'd1));
        key_dir = 8'h04;
        cyc(2);
        voice_dir = 4'b1000;
        voice_valid = 1'b1;
        cyc(1);
        voice_valid = 1'b0;
        check("arb_qc", queue_count, 3'd1);
        check("arb_drop", dropped, 1'b1);
        check("arb_rej", rejected, 1'b0);

        // Push on the tick edge: full drops (pre-pop), then push+pop keeps count
        voice_dir = 4'b0001;
        voice_valid = 1'b1;
        cyc(1);
        voice_valid = 1'b0;
        check("prepop_qc", queue_count, 3'd2);
        sb.push_back(ev(1, 0, 1, 4'b0100, 3'd1));
        enable = 1'b1;
        cyc(7);
        voice_dir = 4'b1000;
        voice_valid = 1'b1;
        cyc(1);
        voice_valid = 1'b0;
        check("prepop_after_qc", queue_count, 3'd1);
        check("prepop_after_cur", cur_dir, 4'b0100);
        sb.push_back(ev(1, 0, 0, 4'b0001, 3'd1));
        cyc(7);
        voice_dir = 4'b0100;
        voice_valid = 1'b1;
        cyc(1);
        voice_valid = 1'b0;
        check("pushpop_qc", queue_count, 3'd1);
        check("pushpop_cur", cur_dir, 4'b0001);

        // Reset mid-tick with a full queue
        voice_dir = 4'b0010;
        voice_valid = 1'b1;
        key_dir = 8'h00;
        cyc(1);
        voice_valid = 1'b0;
        check("midreset_qc_before", queue_count, 3'd2);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        check("midreset_cur", cur_dir, 4'b1000);
        check("midreset_qc", queue_count, 3'd0);
        check("midreset_step", step, 1'b0);
        check("midreset_rej", rejected, 1'b0);
        check("midreset_drop", dropped, 1'b0);
        reset = 1'b0;
        sb.push_back(ev(1, 0, 0, 4'b1000, 3'd0));
        cyc(7);
        check("post_reset_nostep", step, 1'b0);
        cyc(1);
        check("post_reset_step", step, 1'b1);
        enable = 1'b0;
        cyc(3);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
